// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: DIFF = A - B, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output OVF.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // state | meaning
    // IDLE  | waiting for an operand pair
    // SHIFT | one bit per cycle through the full-subtractor cell
    // DONE  | result presented until the consumer takes it
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             br_next;
    logic             d;
    logic             last;

    assign d        = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    assign res_next = WIDTH'({d, res_sr} >> 1);
    assign last     = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SHIFT;
            SHIFT:   if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Result registers are only written on the DONE-entry edge, so no partial value is ever visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr <= a;
                        b_sr <= b;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    br     <= br_next;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        diff   <= res_next;
                        borrow <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        // On the last bit the shift registers hold the operand MSBs.
                        ovf    <= (a_sr[0] ^ b_sr[0]) & (a_sr[0] ^ d);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8): directed vectors with literal expectations plus
// an arithmetic reference model checked on every cycle the result is valid.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    bit   prev_ov = 0;
    bit   stream_on = 0;
    bit   have_rise = 0;
    int   last_rise = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   sx, sy, sd;
        e.d  = W'(int'(x) - int'(y));
        e.br = (x < y);
        sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
        sd = sx - sy;
        e.ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
        return e;
    endfunction

    always @(posedge clk) cyc++;

    // Reference-model monitor: flush on reset, record accepts, check every valid cycle.
    always @(negedge clk) begin
        if (!stream_on) have_rise = 0;
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            prev_ov = 0;
        end else begin
            if (out_valid) begin
                if (!prev_ov) begin
                    check("latency_q", acc_q.size() != 0, 1);
                    if (acc_q.size() != 0) check("latency", cyc, acc_q.pop_front());
                    if (stream_on && have_rise) check("spacing", cyc - last_rise, W + 2);
                    last_rise = cyc;
                    have_rise = 1;
                end
                check("result_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("model_diff", diff, exp_q[0].d);
                    check("model_borrow", borrow, exp_q[0].br);
`ifdef SERIAL_SUB_OVF_EN
                    check("model_ovf", ovf, exp_q[0].ov);
`endif
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b));
                acc_q.push_back(cyc + 1 + W);
            end
            prev_ov = out_valid;
        end
    end

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] ed, input logic eb, input logic eo,
                          input string nm);
        int n;
        a = x;
        b = y;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_accept_timeout"}, n < 40, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_latency"}, n, W);
        check({nm, "_diff"}, diff, ed);
        check({nm, "_borrow"}, borrow, eb);
`ifdef SERIAL_SUB_OVF_EN
        check({nm, "_ovf"}, ovf, eo);
`else
        if (eo) ;
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'd100, 8'd37, 8'd63, 1'b0, 1'b0, "a100_b37");

        // Abort an operation at counter=3 with an asynchronous reset.
        a = 8'd5;
        b = 8'd9;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_diff", diff, 0);
        check("midrst_borrow", borrow, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'd10, 8'd3, 8'd7, 1'b0, 1'b0, "a10_b3");
        run_op(8'd5, 8'd9, 8'hFC, 1'b1, 1'b0, "a5_b9");
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, "aff_bff");
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, "a00_b01");
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "a80_b01");
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "a7f_bff");

        // Backpressure: DONE held while new operands are offered and ignored.
        out_ready = 1'b0;
        run_op(8'd200, 8'd50, 8'h96, 1'b0, 1'b0, "bp_a200_b50");
        a = 8'd1;
        b = 8'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_diff", diff, 8'h96);
            check("bp_borrow", borrow, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        run_op(8'd1, 8'd1, 8'd0, 1'b0, 1'b0, "a1_b1");

        // Back-to-back stream; model checks values, monitor checks spacing.
        stream_on = 1;
        in_valid = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
        for (int i = 0; i < 16; i++) begin
            n = 0;
            while (!in_ready && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            check("stream_accept_timeout", n < 40, 1);
            @(posedge clk); #1;
            a = W'($urandom);
            b = W'($urandom);
        end
        in_valid = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("stream_drain", exp_q.size(), 0);
        stream_on = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing DIFF = A − B, plus borrow-out.
- Processes operands LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop.
- Sits beside the combinational full_adder/half_adder arithmetic cells as their area-minimal, subtract-direction counterpart.
- Operands enter through a valid/ready handshake; results leave through another.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_VALID  input  1  operand pair A/B valid.
- IN_READY  output  1  block can accept an operand pair.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- OUT_VALID  output  1  DIFF/BORROW valid.
- OUT_READY  input  1  consumer accepts the result.
- DIFF  output  WIDTH  A − B mod 2^WIDTH.
- BORROW  output  1  1 when A < B, unsigned.
- OVF  output  1  signed overflow; exists only with SERIAL_SUB_OVF_EN.

Behaviour:
- Reset is asynchronous and active-low; the block has one clock, CLK. RST_N low forces:
  - state IDLE, IN_READY=1, OUT_VALID=0, DIFF=0, BORROW=0, OVF=0;
  - bit counter, operand shift registers and borrow flop cleared.
  - Reset deassertion is synchronised externally.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID & IN_READY: latch A and B into shift registers, clear borrow flop, counter=0, go to SHIFT.
- SHIFT:
  - IN_READY=0, OUT_VALID=0.
  - Each cycle uses a=A_sr[0], b=B_sr[0], br=borrow flop.
  - d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br).
  - d shifts into the MSB of the result register, which shifts right; A_sr and B_sr shift right; counter increments.
  - When counter == WIDTH−1 at the edge: go to DONE. DIFF takes the full result and BORROW takes br_next on that same edge.
- DONE:
  - OUT_VALID=1; DIFF and BORROW held stable.
  - On OUT_READY: go to IDLE; OUT_VALID falls on that edge.
  - IN_READY=0 in DONE, so there is no same-cycle accept. The next operand is accepted one cycle after the result handshake at the earliest.
- Latency: with the accept at edge k, OUT_VALID is high from edge k+WIDTH. Throughput is one result per WIDTH+2 cycles when OUT_READY is held high.
- IN_VALID while busy is ignored; A/B changes during SHIFT/DONE have no effect.
- Backpressure: OUT_READY low holds DONE indefinitely with DIFF/BORROW unchanged.
- WIDTH=1: SHIFT lasts one cycle.
- Reset mid-SHIFT or mid-DONE: the in-flight result is discarded and all outputs return to reset values immediately. No partial result is ever presented.
- DIFF and BORROW keep their last values after returning to IDLE. They are meaningful only while OUT_VALID=1.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- When defined:
  - OVF port exists.
  - Captured on the DONE-entry edge as (A_msb ^ B_msb) & (A_msb ^ d_msb), using the latched operand MSBs.
  - Same validity and hold rules as BORROW; reset 0.
- When undefined:
  - OVF port and its logic are absent.
  - Port list is CLK through BORROW only.

Test Plan:
- Reset with RST_N=0 mid-operation, during SHIFT at counter=3 -> OUT_VALID=0, IN_READY=1, DIFF=0 asynchronously; after release, A=8'd10, B=8'd3 -> DIFF=8'd7, BORROW=0.
- WIDTH=8, A=8'd100, B=8'd37 accepted at edge k -> OUT_VALID high from edge k+8, DIFF=8'd63, BORROW=0.
- A=8'd5, B=8'd9 -> DIFF=8'hFC, BORROW=1; A=8'hFF, B=8'hFF -> DIFF=8'h00, BORROW=0; A=8'h00, B=8'h01 -> DIFF=8'hFF, BORROW=1.
- OUT_READY held low 5 cycles in DONE -> DIFF/BORROW stable, IN_READY=0, new IN_VALID with A=1, B=1 ignored; OUT_READY=1 -> IDLE next edge, then A=1, B=1 -> DIFF=0.
- With SERIAL_SUB_OVF_EN defined: A=8'h80, B=8'h01 -> DIFF=8'h7F, OVF=1, BORROW=0; A=8'h7F, B=8'hFF -> DIFF=8'h80, OVF=1, BORROW=1; A=8'd100, B=8'd37 -> OVF=0.
- Back-to-back stream of 16 random pairs with OUT_READY=1 -> every DIFF/BORROW matches a reference model; result spacing is exactly WIDTH+2 cycles.
